ov7670_capture: RTL and testbench
=================================

OV7670_CAPTURE -- requirements
Module: ov7670_capture

Interface
REQ-001 The block SHALL have parameter H_PIXELS, default 640, pixels stored per line.
REQ-002 The block SHALL have parameter V_LINES, default 480, lines stored per frame.
REQ-003 The block SHALL have port pclk, input, 1, camera pixel clock and the only clock; all inputs are synchronous to it.
REQ-004 The block SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 The block SHALL have port vsync, input, 1, camera frame sync, high during vertical blanking.
REQ-006 The block SHALL have port href, input, 1, high while line bytes are valid.
REQ-007 The block SHALL have port d, input, 8, camera byte, RGB565, high byte first.
REQ-008 The block SHALL have port frame_addr, output, 19, frame-buffer write address.
REQ-009 The block SHALL have port frame_pixel, output, 12, RGB444 write data {R[3:0],G[3:0],B[3:0]}.
REQ-010 The block SHALL have port we, output, 1, frame-buffer write enable, one cycle per stored pixel.
REQ-011 The block SHALL have port frame_done, output, 1, one-cycle pulse at end of a captured frame.

Function
REQ-012 The block SHALL implement states WAIT_VSYNC, WAIT_FRAME and ACTIVE.
REQ-013 WAIT_VSYNC -> WAIT_FRAME SHALL occur when vsync=1.
REQ-014 WAIT_FRAME -> ACTIVE SHALL occur when vsync=0; entering ACTIVE clears line, column, line_base and byte phase.
REQ-015 ACTIVE -> WAIT_FRAME SHALL occur when vsync=1, and frame_done SHALL pulse high for exactly the following cycle.
REQ-016 href and d SHALL be ignored outside ACTIVE.
REQ-017 In ACTIVE with href=1, the byte phase SHALL toggle each cycle: phase 0 latches d as the high byte (R[4:0],G[5:3]); phase 1 completes the pixel with d (G[2:0],B[4:0]).
REQ-018 On phase 1, if column<H_PIXELS and line<V_LINES, the next cycle SHALL present we=1, frame_pixel={R5[4:1],G6[5:2],B5[4:1]} and frame_addr=line_base+column (registered, latency 1 cycle from the second byte).
REQ-019 Column SHALL increment on every phase-1 byte and saturate at H_PIXELS; excess pixels SHALL be dropped with no write.
REQ-020 On href falling edge (href_q=1, href=0) in ACTIVE:
- column SHALL clear;
- byte phase SHALL reset to 0, discarding any lone trailing byte;
- line SHALL increment, saturating at V_LINES;
- line_base SHALL add H_PIXELS while line<V_LINES.
REQ-021 Lines at index >=V_LINES SHALL produce no writes.
REQ-022 frame_addr SHALL never exceed H_PIXELS*V_LINES-1 (307199 at defaults).
REQ-023 frame_addr and frame_pixel SHALL hold their last values while we=0.
REQ-024 If vsync rises in the same cycle as a phase-1 byte, the vsync transition SHALL win and the pixel SHALL be discarded.

Reset
REQ-025 With reset=1 at a pclk edge: state=WAIT_VSYNC; frame_addr=0, frame_pixel=0, we=0, frame_done=0; all counters, href_q and byte phase = 0.
REQ-026 Reset mid-frame SHALL abandon the partial frame; no write SHALL occur until after a complete vsync high-then-low sequence.

Verification
REQ-027 Reset, vsync 1->0, href=1 with bytes F8,00,07,E0 -> we on two cycles: addr 0 data F00, then addr 1 data 0F0.
REQ-028 Line of 642 pixels, then second line -> exactly 640 writes, addr 0..639; second line's first write is at addr 640.
REQ-029 Line of 3 bytes (F8,00,FF), then line with bytes 00,1F -> one write (addr 0, F00); next line's first write is at addr 640 with data 00F (phase realigned).
REQ-030 482 lines of 640 pixels, then vsync rise -> last write at addr 307199, no writes on lines 481-482, frame_done high for exactly one cycle.
REQ-031 Bytes with href=1 before the first vsync after reset, and reset asserted mid-line -> no we; outputs 0 during reset; capture resumes at addr 0 after the next vsync high-then-low.
REQ-032 vsync rising coincident with a phase-1 byte -> no write for that pixel and frame_done pulses.

Source files
------------

// File: rtl/ov7670_capture.sv
// OV7670 capture: assembles RGB565 byte pairs into RGB444 frame-buffer writes with line/column addressing.
// Latency: one pclk from the second byte of a pixel to we/frame_addr/frame_pixel; frame_done one pclk after vsync rises.
// Backpressure: none; the camera cannot be stalled, so pixels past the frame window are dropped without a write.
//
// Ports: pclk/reset (sync, active-high); vsync, href, d[7:0] from the camera;
//        frame_addr[18:0], frame_pixel[11:0], we to the frame buffer; frame_done end-of-frame pulse.
module ov7670_capture #(
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 480
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  d,
    output logic [18:0] frame_addr,
    output logic [11:0] frame_pixel,
    output logic        we,
    output logic        frame_done
);

    localparam int COL_W  = $clog2(H_PIXELS + 1);
    localparam int LINE_W = $clog2(V_LINES + 1);

    typedef enum logic [1:0] {
        WAIT_VSYNC,
        WAIT_FRAME,
        ACTIVE
    } state_t;

    state_t              state_q, state_d;
    logic                href_q, href_d;
    logic                phase_q, phase_d;
    logic [6:0]          hi_q, hi_d;       // {R5[4:1], G6[5:3]}: only the bits that survive RGB444
    logic [COL_W-1:0]    col_q, col_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [18:0]         line_base_q, line_base_d;
    logic [18:0]         addr_q, addr_d;
    logic [11:0]         pix_q, pix_d;
    logic                we_q, we_d;
    logic                done_q, done_d;

    always_comb begin
        state_d     = state_q;
        href_d      = 1'b0;
        phase_d     = phase_q;
        hi_d        = hi_q;
        col_d       = col_q;
        line_d      = line_q;
        line_base_d = line_base_q;
        addr_d      = addr_q;
        pix_d       = pix_q;
        we_d        = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            WAIT_VSYNC: begin
                if (vsync) begin
                    state_d = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (!vsync) begin
                    state_d     = ACTIVE;
                    col_d       = '0;
                    line_d      = '0;
                    line_base_d = '0;
                    phase_d     = 1'b0;
                end
            end
            ACTIVE: begin
                if (vsync) begin
                    // vsync has priority over any byte arriving in the same cycle
                    state_d = WAIT_FRAME;
                    done_d  = 1'b1;
                end else begin
                    // href history is only tracked while capturing, so a stale
                    // high level can never fake a falling edge on frame entry
                    href_d = href;
                    if (href) begin
                        if (!phase_q) begin
                            hi_d    = {d[7:4], d[2:0]};
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if (col_q < COL_W'(H_PIXELS) && line_q < LINE_W'(V_LINES)) begin
                                we_d   = 1'b1;
                                addr_d = line_base_q + 19'(col_q);
                                pix_d  = {hi_q[6:3], hi_q[2:0], d[7], d[4:1]};
                            end
                            if (col_q < COL_W'(H_PIXELS)) begin
                                col_d = col_q + COL_W'(1);
                            end
                        end
                    end else if (href_q) begin
                        // end of line: realign byte phase, drop any lone trailing byte
                        col_d   = '0;
                        phase_d = 1'b0;
                        if (line_q < LINE_W'(V_LINES)) begin
                            line_d      = line_q + LINE_W'(1);
                            line_base_d = line_base_q + 19'(H_PIXELS);
                        end
                    end
                end
            end
            default: state_d = WAIT_VSYNC;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q     <= WAIT_VSYNC;
            href_q      <= 1'b0;
            phase_q     <= 1'b0;
            hi_q        <= '0;
            col_q       <= '0;
            line_q      <= '0;
            line_base_q <= '0;
            addr_q      <= '0;
            pix_q       <= '0;
            we_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            href_q      <= href_d;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            col_q       <= col_d;
            line_q      <= line_d;
            line_base_q <= line_base_d;
            addr_q      <= addr_d;
            pix_q       <= pix_d;
            we_q        <= we_d;
            done_q      <= done_d;
        end
    end

    assign frame_addr  = addr_q;
    assign frame_pixel = pix_q;
    assign we          = we_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Testbench for ov7670_capture: random camera frames against a pixel-level reference model.
// Latency: expects each write one pclk after the second byte of its pixel.
// Backpressure: none; the bench drives bytes freely and records every we pulse.
module tb_ov7670_capture;

    localparam int H = 12;
    localparam int V = 5;

    logic        pclk  = 1'b0;
    logic        reset = 1'b1;
    logic        vsync = 1'b0;
    logic        href  = 1'b0;
    logic [7:0]  d     = 8'h00;
    logic [18:0] frame_addr;
    logic [11:0] frame_pixel;
    logic        we;
    logic        frame_done;

    ov7670_capture #(.H_PIXELS(H), .V_LINES(V)) dut (
        .pclk        (pclk),
        .reset       (reset),
        .vsync       (vsync),
        .href        (href),
        .d           (d),
        .frame_addr  (frame_addr),
        .frame_pixel (frame_pixel),
        .we          (we),
        .frame_done  (frame_done)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // expected and observed writes: address, pixel, cycle
    int exp_a[$], exp_p[$], exp_c[$];
    int got_a[$], got_p[$], got_c[$];
    int done_cnt  = 0;
    int done_snap = 0;

    logic [18:0] prev_a   = '0;
    logic [11:0] prev_p   = '0;
    logic        rst_prev = 1'b1;

    always @(negedge pclk) begin
        if (we === 1'b1) begin
            got_a.push_back(int'(frame_addr));
            got_p.push_back(int'(frame_pixel));
            got_c.push_back(cyc);
            check("addr range", 32'(int'(frame_addr) <= H * V - 1), 32'd1);
        end
        if (frame_done === 1'b1) done_cnt++;
        if (!reset && !rst_prev && we !== 1'b1)
            check("hold while idle", {1'b0, frame_addr, frame_pixel}, {1'b0, prev_a, prev_p});
        prev_a   = frame_addr;
        prev_p   = frame_pixel;
        rst_prev = reset;
    end

    // reference model state: pixel-level bookkeeping of the current frame
    bit         m_active = 0;
    bit         m_phase  = 0;
    bit         m_any    = 0;
    int         m_line   = 0;
    int         m_pix    = 0;
    logic [7:0] m_hi     = '0;

    function automatic int rgb444(input logic [7:0] hi, input logic [7:0] lo);
        logic [15:0] w;
        logic [4:0]  r, b;
        logic [5:0]  g;
        w = {hi, lo};
        r = w[15:11];
        g = w[10:5];
        b = w[4:0];
        return int'({r[4:1], g[5:2], b[4:1]});
    endfunction

    task automatic drive_byte(input logic [7:0] b);
        @(posedge pclk); #1;
        href = 1'b1;
        d    = b;
        if (m_active) begin
            m_any = 1;
            if (m_phase) begin
                if (m_pix < H && m_line < V) begin
                    exp_a.push_back(m_line * H + m_pix);
                    exp_p.push_back(rgb444(m_hi, b));
                    exp_c.push_back(cyc + 1);
                end
                m_pix++;
            end else begin
                m_hi = b;
            end
            m_phase = !m_phase;
        end
    endtask

    task automatic end_line(input int gap);
        @(posedge pclk); #1;
        href = 1'b0;
        d    = 8'($urandom);
        if (m_active && m_any) begin
            m_line++;
            m_pix   = 0;
            m_phase = 0;
            m_any   = 0;
        end
        repeat (gap) @(posedge pclk);
    endtask

    task automatic send_pixels(input int n, input bit odd);
        for (int i = 0; i < n; i++) begin
            drive_byte(8'($urandom));
            drive_byte(8'($urandom));
        end
        if (odd) drive_byte(8'($urandom));
        end_line($urandom_range(0, 3));
    endtask

    task automatic vsync_pulse(input int exp_done);
        check("spurious frame_done", done_cnt, done_snap);
        @(posedge pclk); #1;
        vsync    = 1'b1;
        href     = 1'b0;
        m_active = 0;
        done_snap = done_cnt;
        repeat (4) @(posedge pclk);
        #1;
        check("frame_done pulses", done_cnt - done_snap, exp_done);
        vsync    = 1'b0;
        m_active = 1;
        m_line   = 0;
        m_pix    = 0;
        m_phase  = 0;
        m_any    = 0;
        done_snap = done_cnt;
    endtask

    task automatic check_writes(input string tag);
        int n;
        repeat (3) @(posedge pclk);
        check({tag, " write count"}, got_a.size(), exp_a.size());
        n = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
        for (int i = 0; i < n; i++) begin
            check({tag, " addr"},  got_a[i], exp_a[i]);
            check({tag, " pixel"}, got_p[i], exp_p[i]);
            check({tag, " cycle"}, got_c[i], exp_c[i]);
        end
        exp_a.delete(); exp_p.delete(); exp_c.delete();
        got_a.delete(); got_p.delete(); got_c.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        @(negedge pclk);
        check({tag, " frame_addr"},  frame_addr, 0);
        check({tag, " frame_pixel"}, frame_pixel, 0);
        check({tag, " we"},          we, 0);
        check({tag, " frame_done"},  frame_done, 0);
    endtask

    initial begin
        // power-up reset
        repeat (3) @(posedge pclk);
        check_outputs_zero("reset");
        @(posedge pclk); #1;
        reset = 1'b0;

        // bytes before the first vsync are ignored
        send_pixels(4, 0);
        check_writes("pre-vsync");
        vsync_pulse(0);

        // two known pixels
        drive_byte(8'hF8); drive_byte(8'h00);
        drive_byte(8'h07); drive_byte(8'hE0);
        end_line(2);
        check_writes("basic");

        // lone trailing byte is dropped and phase realigns on the next line
        vsync_pulse(1);
        drive_byte(8'hF8); drive_byte(8'h00); drive_byte(8'hFF);
        end_line(1);
        drive_byte(8'h00); drive_byte(8'h1F);
        end_line(1);
        check_writes("realign");

        // overlong line saturates the column
        vsync_pulse(1);
        send_pixels(H + 2, 0);
        send_pixels(3, 0);
        check_writes("overlong");

        // extra lines beyond the window produce no writes
        vsync_pulse(1);
        for (int l = 0; l < V + 2; l++) send_pixels(H, 0);
        repeat (3) @(posedge pclk);
        check("last addr of full frame", (got_a.size() > 0) ? got_a[got_a.size() - 1] : -1, H * V - 1);
        check_writes("full frame");
        vsync_pulse(1);

        // vsync rising together with a second byte discards that pixel
        send_pixels(2, 0);
        drive_byte(8'($urandom));
        @(posedge pclk); #1;
        d        = 8'($urandom);
        vsync    = 1'b1;
        m_active = 0;
        done_snap = done_cnt;
        repeat (3) @(posedge pclk);
        #1;
        href = 1'b0;
        check("coincident frame_done", done_cnt - done_snap, 1);
        done_snap = done_cnt;
        check_writes("coincident");
        vsync_pulse(0);

        // reset in the middle of a line abandons the frame
        send_pixels(1, 0);
        drive_byte(8'($urandom)); drive_byte(8'($urandom));
        drive_byte(8'($urandom)); drive_byte(8'($urandom));
        @(posedge pclk); #1;
        reset    = 1'b1;
        m_active = 0;
        href     = 1'b1;
        d        = 8'($urandom);
        repeat (2) begin
            @(posedge pclk); #1;
            d = 8'($urandom);
        end
        check_outputs_zero("mid reset");
        @(posedge pclk); #1;
        reset = 1'b0;
        done_snap = done_cnt;
        send_pixels(3, 0);
        check_writes("mid reset");
        vsync_pulse(0);
        send_pixels(2, 0);
        check_writes("resume");

        // random frames
        for (int f = 0; f < 6; f++) begin
            int nl;
            vsync_pulse(1);
            nl = $urandom_range(0, V + 2);
            for (int l = 0; l < nl; l++)
                send_pixels($urandom_range(0, H + 3), $urandom_range(0, 3) == 0);
            check_writes("random");
        end
        vsync_pulse(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
